rom_fetch_unit: RTL and testbench
=================================

# rom_fetch_unit

Sequential instruction-fetch front end that drives the boot/program ROM address and consumes the ROM's 32-bit read data. It sits between the combinational `_ROM_32bit_16aline`/`ROM_BOOT` and the decode stage. It keeps a byte-addressed program counter and buffers fetched words in a 2-entry queue. Instructions go to decode over a valid/ready handshake; redirects (branch/jump) flush the queue.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, byte address fetched first after reset; must be word-aligned.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `fetch_en`  in  1  1 = fetch allowed; 0 = PC holds and no pushes occur.
- `rom_address`  out  16  byte address to the ROM. Always equals PC, combinational from the PC register.
- `rom_data`  in  32  ROM read data for `rom_address`, valid in the same cycle.
- `redirect_valid`  in  1  load a new PC and flush the queue.
- `redirect_pc`  in  16  redirect target byte address.
- `instr_valid`  out  1  head of the queue is valid.
- `instr_ready`  in  1  decode accepts the head this cycle.
- `instr`  out  32  head instruction word.
- `instr_pc`  out  16  byte address of `instr`.
- `misalign_err`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- States:
  - RUN: normal fetch.
  - HALT: fetch stopped. Entered only when the alignment check is compiled in.
- Pop occurs when `instr_valid & instr_ready`.
- Push occurs when all of the following hold: state is RUN, `fetch_en` = 1, `!redirect_valid`, and (count < 2 or a pop happens this cycle). A push captures {PC, `rom_data`}, and then PC <= PC + 4.
- PC arithmetic is 16-bit modulo: 16'hFFFC + 4 = 16'h0000. Wrap is silent.
- Redirect has priority over push and pop:
  - At the edge: queue count <= 0 and PC <= `redirect_pc` with bits [1:0] forced to 0.
  - Any concurrent pop or push in that cycle is discarded.
- Queue is FIFO with depth 2:
  - Push and pop in the same cycle at count 2 is legal; count stays 2.
  - Push at count 2 without a pop never happens, so the queue never overflows.
- `instr`/`instr_pc` hold their values while `instr_valid` = 1 and `instr_ready` = 0.
- Reset values: PC = `RESET_PC` (so `rom_address` = `RESET_PC`), count 0, `instr_valid` 0, `instr` 0, `instr_pc` 0, `misalign_err` 0, state RUN.
- Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge.

## Timing
- Fetch latency: the word at `rom_address` appears on `instr` one edge later. For example, `instr_valid` first rises at the first edge after `reset_n` deasserts, provided `fetch_en` = 1.
- Throughput: 1 instruction/cycle with `instr_ready` held at 1.
- Redirect latency:
  - The edge where `redirect_valid` = 1 empties the queue, so `instr_valid` = 0 in the next cycle.
  - The following edge pushes the target word, so `instr_valid` = 1 two edges after the redirect cycle.
- Backpressure:
  - With `instr_ready` = 0, the queue fills in 2 cycles. PC then stops advancing and `rom_address` holds.
  - Both buffered words are delivered in order once ready returns.

## Configuration
- `ROM_FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]` != 0 sets `misalign_err` = 1 and enters HALT. The queue is flushed and PC is loaded with the aligned value.
  - While in HALT, no pushes occur and any remaining entries drain normally.
  - An aligned redirect clears `misalign_err` and returns to RUN; reset also clears both.
- `ROM_FETCH_ALIGN_CHECK_EN` not defined:
  - Low address bits are silently cleared.
  - HALT is unreachable.
  - `misalign_err` is tied to 0.

## Structure
- Shared header/package `fetch_defs` contains:
  - `FETCH_WORD_BYTES` = 4.
  - `FETCH_ADDR_W` = 16, `FETCH_DATA_W` = 32.
  - State encodings `FETCH_ST_RUN`, `FETCH_ST_HALT`.
- One sub-module, `fetch_fifo2`: 2-entry, 48-bit-wide queue of {pc, instr} with push/pop/flush/count.
- The top level holds the PC register, the state machine, and the push/pop/redirect arbitration.

## Test plan
All tests use the `ROM_BOOT` image, with `instr_ready` = 1 unless stated otherwise.
- Reset release, `fetch_en` = 1 → first accepted {`instr_pc`, `instr`} = {0x0000, 0x82BF7857}, then {0x0004, 0xFCACD0A9}, one per cycle.
- Hold `instr_ready` = 0 for 5 cycles after reset:
  - `rom_address` freezes at 0x0008.
  - When ready rises, the outputs are 0x82BF7857 then 0xFCACD0A9, with no gap.
- Redirect to 0x001C during streaming:
  - `instr_valid` = 0 in the next cycle.
  - Two edges later, `instr` = 0x9F7A8229 and `instr_pc` = 0x001C.
- Redirect to 0x000E:
  - With the macro: `misalign_err` = 1, no further valid instructions. A following redirect to 0x000C clears the flag and yields 0xFAFF41FE.
  - Without the macro: `instr_pc` = 0x000C, `instr` = 0xFAFF41FE.
- Redirect to 0xFFFC, then stream → `instr_pc` 0xFFFC, then 0x0000 (wrap), then `instr` = 0x82BF7857.
- Assert `reset_n` = 0 mid-stream with 2 entries queued → `instr_valid` drops to 0 immediately and `rom_address` = 0x0000 immediately, both without waiting for a clock edge.

Source files
------------

// File: rtl/rom_fetch_unit_pkg.sv
// Shared fetch definitions: widths, FSM state encoding, queue entry layout and
// address alignment helpers used by rom_fetch_unit and its queue.
package fetch_defs;

    localparam int unsigned FETCH_WORD_BYTES = 4;
    localparam int unsigned FETCH_ADDR_W     = 16;
    localparam int unsigned FETCH_DATA_W     = 32;
    localparam int unsigned FETCH_ENTRY_W    = FETCH_ADDR_W + FETCH_DATA_W;

    typedef enum logic [0:0] {
        FETCH_ST_RUN  = 1'b0,
        FETCH_ST_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] word;
    } fetch_entry_t;

    function automatic logic [FETCH_ADDR_W-1:0] fetch_align(input logic [FETCH_ADDR_W-1:0] addr);
        return {addr[FETCH_ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic fetch_misaligned(input logic [FETCH_ADDR_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rom_fetch_unit_if.sv
// Fetch-unit bus: ROM address/data, redirect request and the decode handshake.
// master = fetch unit, slave = surrounding ROM/decode environment.
interface rom_fetch_unit_if;
    import fetch_defs::*;

    logic                    fetch_en;
    logic [FETCH_ADDR_W-1:0] rom_address;
    logic [FETCH_DATA_W-1:0] rom_data;
    logic                    redirect_valid;
    logic [FETCH_ADDR_W-1:0] redirect_pc;
    logic                    instr_valid;
    logic                    instr_ready;
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] instr_pc;
    logic                    misalign_err;

    modport master (
        input  fetch_en, rom_data, redirect_valid, redirect_pc, instr_ready,
        output rom_address, instr_valid, instr, instr_pc, misalign_err
    );

    modport slave (
        output fetch_en, rom_data, redirect_valid, redirect_pc, instr_ready,
        input  rom_address, instr_valid, instr, instr_pc, misalign_err
    );

endinterface

// File: rtl/rom_fetch_unit_fifo2.sv
// fetch_fifo2: 2-entry shift queue of {pc, instr}. The head sits in its own
// register so the decode-facing outputs come straight from flops.
module fetch_fifo2
    import fetch_defs::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         valid
);

    fetch_entry_t head_r;
    fetch_entry_t tail_r;
    logic [1:0]   count_r;
    logic         pop_s;
    logic         push_s;

    // Guard against underflow/overflow even if the caller misbehaves.
    always_comb begin
        pop_s  = pop & (count_r != 2'd0);
        push_s = push & ((count_r != 2'd2) | pop_s);
    end

    // Queue storage and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= fetch_entry_t'(48'h0);
            tail_r  <= fetch_entry_t'(48'h0);
            count_r <= 2'd0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= din;
                    end else begin
                        tail_r <= din;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        head_r <= tail_r;
                    end else begin
                        head_r <= head_r;
                    end
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd2) begin
                        head_r <= tail_r;
                        tail_r <= din;
                    end else begin
                        head_r <= din;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign head  = head_r;
    assign count = count_r;
    assign valid = (count_r != 2'd0);

endmodule

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: PC register, RUN/HALT state machine and push/pop/redirect
// arbitration in front of a 2-entry fetch queue. Define ROM_FETCH_ALIGN_CHECK_EN
// to halt on misaligned redirects and report them on misalign_err.
module rom_fetch_unit
    import fetch_defs::*;
#(
    parameter logic [FETCH_ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              reset_n,
    rom_fetch_unit_if.master  bus
);

    logic [FETCH_ADDR_W-1:0] pc_r;
    fetch_state_t            state_r;
    logic                    pop_s;
    logic                    push_s;
    logic [1:0]              count_s;
    logic                    valid_s;
    fetch_entry_t            head_s;
    fetch_entry_t            din_s;

    // Redirect wins: it suppresses both the pop and the push of its cycle.
    always_comb begin
        pop_s  = valid_s & bus.instr_ready & ~bus.redirect_valid;
        push_s = (state_r == FETCH_ST_RUN) & bus.fetch_en & ~bus.redirect_valid
                 & ((count_s != 2'd2) | pop_s);
        din_s  = {pc_r, bus.rom_data};
    end

`ifdef ROM_FETCH_ALIGN_CHECK_EN
    logic misalign_r;

    // PC and fetch state machine; misaligned redirects halt fetching.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r       <= fetch_align(RESET_PC);
            state_r    <= FETCH_ST_RUN;
            misalign_r <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc_r <= fetch_align(bus.redirect_pc);
            if (fetch_misaligned(bus.redirect_pc)) begin
                state_r    <= FETCH_ST_HALT;
                misalign_r <= 1'b1;
            end else begin
                state_r    <= FETCH_ST_RUN;
                misalign_r <= 1'b0;
            end
        end else begin
            case (state_r)
                FETCH_ST_RUN: begin
                    if (push_s) begin
                        pc_r <= pc_r + FETCH_ADDR_W'(FETCH_WORD_BYTES);
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                FETCH_ST_HALT: begin
                    pc_r <= pc_r;
                end
                default: begin
                    state_r <= FETCH_ST_RUN;
                end
            endcase
        end
    end

    assign bus.misalign_err = misalign_r;
`else
    // PC and fetch state machine; low redirect bits are dropped silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r    <= fetch_align(RESET_PC);
            state_r <= FETCH_ST_RUN;
        end else if (bus.redirect_valid) begin
            pc_r    <= fetch_align(bus.redirect_pc);
            state_r <= FETCH_ST_RUN;
        end else begin
            case (state_r)
                FETCH_ST_RUN: begin
                    if (push_s) begin
                        pc_r <= pc_r + FETCH_ADDR_W'(FETCH_WORD_BYTES);
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                default: begin
                    state_r <= FETCH_ST_RUN;
                end
            endcase
        end
    end

    assign bus.misalign_err = 1'b0;
`endif

    fetch_fifo2 u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (bus.redirect_valid),
        .din     (din_s),
        .head    (head_s),
        .count   (count_s),
        .valid   (valid_s)
    );

    assign bus.rom_address = pc_r;
    assign bus.instr_valid = valid_s;
    assign bus.instr       = head_s.word;
    assign bus.instr_pc    = head_s.pc;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Scoreboard bench for rom_fetch_unit: directed phases push expected {pc, instr}
// words; a negedge monitor pops and compares each accepted instruction.
module tb_rom_fetch_unit;
    import fetch_defs::*;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;
    logic [47:0] sb[$];
    logic [47:0] mon_exp;

    always #5 clk = ~clk;

    rom_fetch_unit_if bus();

    rom_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Stand-in for the boot ROM: known image words plus a deterministic filler.
    function automatic logic [31:0] rom_word(input logic [15:0] a);
        case (a)
            16'h0000: rom_word = 32'h82BF7857;
            16'h0004: rom_word = 32'hFCACD0A9;
            16'h000C: rom_word = 32'hFAFF41FE;
            16'h001C: rom_word = 32'h9F7A8229;
            default:  rom_word = {a ^ 16'hC3A5, ~a};
        endcase
    endfunction

    assign bus.rom_data = rom_word(bus.rom_address);

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] pc, input logic [31:0] word);
        sb.push_back({pc, word});
    endtask

    task automatic apply_reset(input logic fe, input logic rdy);
        reset_n            = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.fetch_en       = fe;
        bus.instr_ready    = rdy;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (sb.size() != 0 && n < budget);
        check("drain_done", 48'(sb.size()), 48'd0);
    endtask

    // Monitor: every accepted instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_instr: got pc=%h instr=%h, required none",
                         bus.instr_pc, bus.instr);
            end else begin
                mon_exp = sb.pop_front();
                check("stream", {bus.instr_pc, bus.instr}, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset values, then free streaming.
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.fetch_en       = 1'b1;
        bus.instr_ready    = 1'b1;
        reset_n            = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rom_address", 48'(bus.rom_address), 48'h0000);
        check("rst_instr_valid", 48'(bus.instr_valid), 48'h0);
        check("rst_instr",       48'(bus.instr),       48'h0);
        check("rst_instr_pc",    48'(bus.instr_pc),    48'h0);
        check("rst_misalign",    48'(bus.misalign_err), 48'h0);
        push_exp(16'h0000, 32'h82BF7857);
        push_exp(16'h0004, 32'hFCACD0A9);
        push_exp(16'h0008, rom_word(16'h0008));
        push_exp(16'h000C, 32'hFAFF41FE);
        reset_n = 1'b1;
        drain(20);
        bus.instr_ready = 1'b0;
        bus.fetch_en    = 1'b0;

        // Backpressure: queue fills, PC freezes, then both words drain in order.
        apply_reset(1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("bp_rom_address", 48'(bus.rom_address), 48'h0008);
        check("bp_hold_valid",  48'(bus.instr_valid), 48'h1);
        check("bp_hold_head",   {bus.instr_pc, bus.instr}, {16'h0000, 32'h82BF7857});
        push_exp(16'h0000, 32'h82BF7857);
        push_exp(16'h0004, 32'hFCACD0A9);
        push_exp(16'h0008, rom_word(16'h0008));
        bus.instr_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_no_gap", {47'(bus.instr_pc), bus.instr_valid}, {47'h0004, 1'b1});
        drain(10);
        bus.instr_ready = 1'b0;
        bus.fetch_en    = 1'b0;

        // Redirect during streaming.
        apply_reset(1'b1, 1'b1);
        push_exp(16'h0000, 32'h82BF7857);
        push_exp(16'h0004, 32'hFCACD0A9);
        drain(10);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h001C;
        push_exp(16'h001C, 32'h9F7A8229);
        push_exp(16'h0020, rom_word(16'h0020));
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        check("redir_flush_valid", 48'(bus.instr_valid), 48'h0);
        @(posedge clk);
        #1;
        check("redir_target_valid", 48'(bus.instr_valid), 48'h1);
        check("redir_target_head", {bus.instr_pc, bus.instr}, {16'h001C, 32'h9F7A8229});
        drain(10);
        bus.instr_ready = 1'b0;
        bus.fetch_en    = 1'b0;

        // Misaligned redirect to 0x000E.
        apply_reset(1'b1, 1'b1);
        push_exp(16'h0000, 32'h82BF7857);
        push_exp(16'h0004, 32'hFCACD0A9);
        drain(10);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h000E;
`ifdef ROM_FETCH_ALIGN_CHECK_EN
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        check("mis_err_set",   48'(bus.misalign_err), 48'h1);
        check("mis_flush",     48'(bus.instr_valid),  48'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("mis_halt_no_valid", 48'(bus.instr_valid), 48'h0);
        end
        check("mis_halt_pc", 48'(bus.rom_address), 48'h000C);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h000C;
        push_exp(16'h000C, 32'hFAFF41FE);
        push_exp(16'h0010, rom_word(16'h0010));
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        check("mis_err_clear", 48'(bus.misalign_err), 48'h0);
`else
        push_exp(16'h000C, 32'hFAFF41FE);
        push_exp(16'h0010, rom_word(16'h0010));
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        check("mis_err_tied", 48'(bus.misalign_err), 48'h0);
        check("mis_flush",    48'(bus.instr_valid),  48'h0);
`endif
        drain(10);
        bus.instr_ready = 1'b0;
        bus.fetch_en    = 1'b0;

        // PC wrap from 0xFFFC to 0x0000.
        apply_reset(1'b1, 1'b1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'hFFFC;
        push_exp(16'hFFFC, rom_word(16'hFFFC));
        push_exp(16'h0000, 32'h82BF7857);
        push_exp(16'h0004, 32'hFCACD0A9);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        check("wrap_rom_address", 48'(bus.rom_address), 48'hFFFC);
        drain(10);
        bus.instr_ready = 1'b0;
        bus.fetch_en    = 1'b0;

        // Asynchronous reset with two entries queued.
        apply_reset(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("areset_pre_addr",  48'(bus.rom_address), 48'h0008);
        check("areset_pre_valid", 48'(bus.instr_valid), 48'h1);
        reset_n = 1'b0;
        #1;
        check("areset_valid", 48'(bus.instr_valid), 48'h0);
        check("areset_addr",  48'(bus.rom_address), 48'h0000);
        check("areset_instr", 48'(bus.instr),       48'h0);
        #10;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
